uart_mmio: RTL and testbench

Memory-mapped UART peripheral with parametrised baud rate and TX/RX FIFOs. It plugs into the CPU's valid/ready memory bus alongside the BRAM and LED controllers, replacing the fixed-byte, transmit-only UART path. It contains its own 8N1 serializer and deserializer, sticky error flags and an RX interrupt.

---
 rtl/uart_mmio_if.sv | 14 +
 rtl/uart_mmio.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_if.sv
// CPU memory-bus port: a request is held until the slave returns a one-cycle ready pulse.
interface uart_mmio_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs; bus ready pulses one cycle after accept.
// DATA writes stall while the TX FIFO is full; RX bytes arriving at a full FIFO are dropped as overrun.
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign head_o  = mem_q[rd_ptr_q];
    // A push into a full FIFO is accepted when the same cycle frees an entry.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

module uart_mmio #(
    parameter int CLK_HZ   = 25_000_000,
    parameter int BAUD     = 115_200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_mmio_if.slave bus,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       irq_o
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);

    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t     tx_state_q;
    logic          tx_q;
    logic [8:0]    tx_sh_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    rx_state_t     rx_state_q;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [7:0]    rx_sh_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_en_q, irq_en_d, ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;

    logic       tx_push, tx_pop, tx_empty, tx_full, tx_last, tx_space;
    logic [7:0] tx_head, rx_head;
    logic       rx_push, rx_pop, rx_empty, rx_full, stop_smp;
    logic       acc, is_wr, sel_data, sel_ctl, ctl_wr, clr;
    logic [31:0] status;
    logic       unused_bits;

    assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_addr[1:0], bus.mem_wdata[31:8]};

    uart_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(tx_push), .push_dat_i(bus.mem_wdata[7:0]),
        .pop_i(tx_pop), .head_o(tx_head), .empty_o(tx_empty), .full_o(tx_full));

    uart_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(rx_push), .push_dat_i(rx_sh_q),
        .pop_i(rx_pop), .head_o(rx_head), .empty_o(rx_empty), .full_o(rx_full));

    // Bus decode; no new accept in the ready cycle.
    assign acc      = bus.mem_valid && !ready_q;
    assign is_wr    = |bus.mem_wstrb;
    assign sel_data = (bus.mem_addr[3:2] == 2'd0);
    assign sel_ctl  = (bus.mem_addr[3:2] == 2'd1);
    assign ctl_wr   = acc && is_wr && sel_ctl;
    assign clr      = ctl_wr && bus.mem_wdata[0];
    assign tx_space = !tx_full || tx_pop;
    assign tx_push  = acc && is_wr && sel_data && tx_space;
    assign rx_pop   = acc && !is_wr && sel_data && !rx_empty;

    assign tx_last  = (tx_state_q == TX_SEND) && (tx_cnt_q == BIT_END) && (tx_bit_q == 4'd9);
    assign tx_pop   = !tx_empty && ((tx_state_q == TX_IDLE) || tx_last);
    assign stop_smp = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_END);
    assign rx_push  = stop_smp && rx_s2_q;

    assign status = {23'b0, irq_en_q, 1'b0, (tx_state_q == TX_SEND), ferr_q, ovr_q,
                     rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        ready_d  = acc && !(is_wr && sel_data && !tx_space);
        rdata_d  = '0;
        if (acc && !is_wr) begin
            if (sel_data)     rdata_d = rx_empty ? 32'h8000_0000 : {24'b0, rx_head};
            else if (sel_ctl) rdata_d = status;
        end
        irq_en_d = ctl_wr ? bus.mem_wdata[1] : irq_en_q;
        // A new error in the clearing cycle wins.
        ovr_d    = (ovr_q && !clr) || (rx_push && rx_full && !rx_pop);
        ferr_d   = (ferr_q && !clr) || (stop_smp && !rx_s2_q);
        irq_d    = irq_en_q && !rx_empty;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_en_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            irq_en_q <= irq_en_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            irq_q    <= irq_d;
        end
    end

    // TX: reloading on the stop-bit's last cycle keeps back-to-back frames gap-free.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_sh_q    <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_pop) begin
            tx_state_q <= TX_SEND;
            tx_q       <= 1'b0;
            tx_sh_q    <= {1'b1, tx_head};
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_state_q == TX_SEND) begin
            if (tx_cnt_q == BIT_END) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_state_q <= TX_IDLE;
                    tx_q       <= 1'b1;
                end else begin
                    tx_bit_q <= tx_bit_q + 1'b1;
                    tx_q     <= tx_sh_q[0];
                    tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign tx_o          = tx_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_uart_mmio.sv
// Randomised bench for uart_mmio: stimulus pushes expected bus reads and TX bytes into queues,
// independent monitors on the bus and on the tx line pop and compare them.
`timescale 1ns/1ps
module tb_uart_mmio;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_i = 1'b1;
    logic tx_o, irq_o;

    uart_mmio_if bus();

    uart_mmio #(.CLK_HZ(1_600_000), .BAUD(100_000), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .rx_i(rx_i), .tx_o(tx_o), .irq_o(irq_o));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, rst_epoch = 0;
    always @(posedge clk) begin
        cyc++;
        if (!reset_n) rst_epoch++;
    end

    // Scoreboard queues
    logic [31:0] rd_exp[$];
    bit          rd_chk[$];
    string       rd_name[$];
    logic [7:0]  tx_exp[$];
    int          tx_starts[$];

    // Reference model of the register-visible state
    logic [7:0] m_rx[$];
    bit         m_ovr, m_ferr, m_irq_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit busy, input bit txe, input bit txf);
        logic [31:0] s;
        s    = '0;
        s[0] = txf;
        s[1] = txe;
        s[2] = (m_rx.size() == 0);
        s[3] = (m_rx.size() == 16);
        s[4] = m_ovr;
        s[5] = m_ferr;
        s[6] = busy;
        s[8] = m_irq_en;
        return s;
    endfunction

    // Bus monitor
    logic [31:0] mon_e;
    bit          mon_c;
    string       mon_n;
    always @(negedge clk) begin
        if (reset_n && bus.mem_ready) begin
            if (rd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_ready unexpected completion rdata=%h", bus.mem_rdata);
            end else begin
                mon_e = rd_exp.pop_front();
                mon_c = rd_chk.pop_front();
                mon_n = rd_name.pop_front();
                if (mon_c) chk(mon_n, bus.mem_rdata, mon_e);
            end
        end
    end

    // TX line monitor: samples each bit at its centre
    initial begin : tx_mon
        logic       prev;
        logic [9:0] f;
        logic [7:0] e;
        int         ep;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n && prev && !tx_o) begin
                ep = rst_epoch;
                tx_starts.push_back(cyc);
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clk);
                    f[k] = tx_o;
                end
                prev = tx_o;
                if (ep == rst_epoch) begin
                    if (tx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_frame unexpected frame=%h", f);
                    end else begin
                        e = tx_exp.pop_front();
                        chk("tx_frame", {22'b0, f}, {22'b0, 1'b1, e, 1'b0});
                    end
                end
            end else begin
                prev = tx_o;
            end
        end
    end

    task automatic bus_xfer(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input bit c, input logic [31:0] e, input string nm,
                            output int waited, output int rcyc);
        logic [31:0] addr;
        rd_exp.push_back(e);
        rd_chk.push_back(c);
        rd_name.push_back(nm);
        addr      = $urandom();
        addr[3:2] = a;
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!bus.mem_ready && waited < 4000);
        if (!bus.mem_ready) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout %s actual=no_ready required=ready", nm);
            void'(rd_exp.pop_back());
            void'(rd_chk.pop_back());
            void'(rd_name.pop_back());
        end
        rcyc = cyc;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic wr_data(input logic [7:0] b, output int waited, output int rcyc);
        logic [31:0] wd;
        wd = $urandom();
        wd[7:0] = b;
        tx_exp.push_back(b);
        bus_xfer(2'd0, wd, 4'($urandom_range(1, 15)), 1'b0, '0, "wr_data", waited, rcyc);
    endtask

    task automatic rd_data();
        logic [31:0] e;
        int w, rc;
        if (m_rx.size() > 0) e = {24'b0, m_rx.pop_front()};
        else                 e = 32'h8000_0000;
        bus_xfer(2'd0, $urandom(), 4'h0, 1'b1, e, "rd_data", w, rc);
    endtask

    task automatic rd_status(input bit busy, input bit txe, input bit txf);
        int w, rc;
        bus_xfer(2'd1, $urandom(), 4'h0, 1'b1, exp_status(busy, txe, txf), "rd_status", w, rc);
    endtask

    task automatic wr_ctl(input logic [31:0] wd);
        int w, rc;
        if (wd[0]) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
        m_irq_en = wd[1];
        bus_xfer(2'd1, wd, 4'hF, 1'b0, '0, "wr_ctl", w, rc);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            repeat (CPB) @(posedge clk);
        end
        rx_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        if (!stop)                  m_ferr = 1'b1;
        else if (m_rx.size() == 16) m_ovr  = 1'b1;
        else                        m_rx.push_back(b);
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_exp.size() != 0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        if (tx_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL tx_drain_timeout actual=%0d required=0", tx_exp.size());
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic chk_irq();
        repeat (2) @(posedge clk);
        #1;
        chk("irq", 32'(irq_o), 32'(m_irq_en && (m_rx.size() > 0)));
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w, rc, w18, rc18, op;
        logic [7:0] b;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = 4'h0;
        m_ovr = 1'b0; m_ferr = 1'b0; m_irq_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        rd_status(1'b0, 1'b1, 1'b0);

        // Single 0x55 frame, busy while shifting
        wr_data(8'h55, w, rc);
        chk("wr_latency", 32'(w), 32'd1);
        repeat (20) @(posedge clk);
        rd_status(1'b1, 1'b1, 1'b0);
        wait_tx_idle();
        rd_status(1'b0, 1'b1, 1'b0);

        // Unmapped registers read 0 and ignore writes
        bus_xfer(2'd2, 32'h0, 4'h0, 1'b1, 32'h0, "rd_unmapped2", w, rc);
        bus_xfer(2'd3, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, "wr_unmapped3", w, rc);
        bus_xfer(2'd3, 32'h0, 4'h0, 1'b1, 32'h0, "rd_unmapped3", w, rc);
        rd_status(1'b0, 1'b1, 1'b0);

        // Burst: the 18th write finds the FIFO full and waits for the end of frame 1
        tx_starts.delete();
        w18 = 0; rc18 = 0;
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom());
            wr_data(b, w, rc);
            if (i == 16) chk("wr17_latency", 32'(w), 32'd1);
            if (i == 17) begin
                w18  = w;
                rc18 = rc;
            end
        end
        chk("wr18_stalled", 32'(w18 > 1), 32'd1);
        wait_tx_idle();
        chk("burst_frames", 32'(tx_starts.size()), 32'd18);
        if (tx_starts.size() == 18) begin
            chk("wr18_ready_at_pop", 32'(rc18), 32'(tx_starts[1]));
            for (int i = 1; i < 18; i++)
                chk("gap_free", 32'(tx_starts[i] - tx_starts[i-1]), 32'(10 * CPB));
        end
        rd_status(1'b0, 1'b1, 1'b0);

        // RX 0xA3 with interrupt enabled
        wr_ctl(32'h2);
        send_rx(8'hA3, 1'b1);
        rd_status(1'b0, 1'b1, 1'b0);
        chk_irq();
        rd_data();
        rd_data();
        chk_irq();

        // Overrun: 17 frames without reading
        for (int i = 0; i < 17; i++) send_rx(8'($urandom()), 1'b1);
        rd_status(1'b0, 1'b1, 1'b0);
        wr_ctl(32'h3);
        rd_status(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) rd_data();
        chk_irq();

        // Framing error, then a short glitch
        send_rx(8'($urandom()), 1'b0);
        rd_status(1'b0, 1'b1, 1'b0);
        rd_data();
        wr_ctl(32'h1);
        rd_status(1'b0, 1'b1, 1'b0);
        rx_i = 1'b0;
        repeat (4) @(posedge clk);
        rx_i = 1'b1;
        repeat (40) @(posedge clk);
        rd_status(1'b0, 1'b1, 1'b0);
        rd_data();

        // Random mix against the model
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: send_rx(8'($urandom()), ($urandom_range(0, 7) != 0));
                1: rd_data();
                2: rd_status(1'b0, 1'b1, 1'b0);
                3: begin
                    for (int j = 0; j < $urandom_range(1, 3); j++) wr_data(8'($urandom()), w, rc);
                    wait_tx_idle();
                end
                default: wr_ctl(32'($urandom_range(0, 3)));
            endcase
            chk_irq();
        end

        // Reset in the middle of a TX frame
        wr_data(8'h00, w, rc);
        repeat (60) @(posedge clk);
        #1;
        chk("tx_mid_frame", 32'(tx_o), 32'd0);
        reset_n = 1'b0;
        tx_exp.delete();
        m_rx.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_irq_en = 1'b0;
        @(posedge clk);
        #1;
        chk("tx_after_reset", 32'(tx_o), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("tx_idle_after_reset", 32'(tx_o), 32'd1);
        rd_status(1'b0, 1'b1, 1'b0);
        chk("irq_after_reset", 32'(irq_o), 32'd0);

        repeat (20) @(posedge clk);
        chk("tx_drain", 32'(tx_exp.size()), 32'd0);
        chk("rd_drain", 32'(rd_exp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
